instruction_memory_banked: RTL

INSTRUCTION_MEMORY_BANKED -- requirements
Module: instruction_memory_banked

---
 rtl/instruction_memory_banked.sv | 128 ++++++++++++
 1 files changed

// File: rtl/instruction_memory_banked.sv
// Banked instruction memory: NUM_PROGS program slots of PROG_SIZE words each.
// A loader FSM fills one slot from a valid-qualified word stream. The fetch
// port reads one word per cycle with a registered output, and fetches are
// dropped while the loader is busy.
//
// state | meaning
// IDLE  | fetches served; load_start latches a slot and begins a load
// LOAD  | load_ready=1; each load_valid word is written at slot/counter
// DONE  | one-cycle load_done pulse after the last word of the slot
module instruction_memory_banked #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 10,
    parameter int                PROG_SIZE = 16,
    parameter int                NUM_PROGS = 4,
    parameter logic [DATA_W-1:0] NOP_WORD  = '0
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         fetch_en,
    input  logic [$clog2(NUM_PROGS)-1:0] prog_sel,
    input  logic [ADDR_W-1:0]            address,
    output logic [DATA_W-1:0]            instrucao,
    output logic                         instr_valid,
    output logic                         fault,
    input  logic                         load_start,
    input  logic [$clog2(NUM_PROGS)-1:0] load_prog,
    input  logic                         load_valid,
    input  logic [DATA_W-1:0]            load_data,
    output logic                         load_ready,
    output logic                         load_done,
    output logic                         busy
);

    localparam int SEL_W = $clog2(NUM_PROGS);
    localparam int OFF_W = $clog2(PROG_SIZE);
    localparam int DEPTH = NUM_PROGS * PROG_SIZE;
    localparam logic [OFF_W-1:0]  LAST_WORD = OFF_W'(PROG_SIZE - 1);
    localparam logic [ADDR_W:0]   PROG_SIZE_EXT = (ADDR_W + 1)'(PROG_SIZE);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t             state;
    state_t             next_state;
    logic [SEL_W-1:0]   slot;
    logic [OFF_W-1:0]   counter;
    logic [DATA_W-1:0]  mem [0:DEPTH-1];

    logic                   in_range;
    logic [SEL_W+OFF_W-1:0] fetch_idx;
    logic [SEL_W+OFF_W-1:0] load_idx;

    // Slots are power-of-two sized, so the physical index is a plain concat;
    // out-of-range offsets are caught by in_range before any read happens.
    assign in_range  = {1'b0, address} < PROG_SIZE_EXT;
    assign fetch_idx = {prog_sel, address[OFF_W-1:0]};
    assign load_idx  = {slot, counter};

    // Loader state register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Loader next-state and status outputs.
    always_comb begin
        next_state = state;
        load_ready = 1'b0;
        load_done  = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (load_start) next_state = LOAD;
            end
            LOAD: begin
                load_ready = 1'b1;
                busy       = 1'b1;
                if (load_valid && counter == LAST_WORD) next_state = DONE;
            end
            DONE: begin
                load_done  = 1'b1;
                busy       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Slot latch and word counter; the counter stops at the last word instead
    // of wrapping so it can never address the next slot.
    always_ff @(posedge clock) begin
        if (reset) begin
            slot    <= '0;
            counter <= '0;
        end else begin
            if (state == IDLE && load_start) begin
                slot    <= load_prog;
                counter <= '0;
            end else if (state == LOAD && load_valid && counter != LAST_WORD) begin
                counter <= counter + 1'b1;
            end
        end
    end

    // Memory write port; contents survive reset, but a reset cycle never writes.
    always_ff @(posedge clock) begin
        if (!reset && state == LOAD && load_valid) mem[load_idx] <= load_data;
    end

    // Registered fetch port with sticky out-of-range fault.
    always_ff @(posedge clock) begin
        if (reset) begin
            instrucao   <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else if (fetch_en && !busy) begin
            instr_valid <= 1'b1;
            if (in_range) begin
                instrucao <= mem[fetch_idx];
            end else begin
                instrucao <= NOP_WORD;
                fault     <= 1'b1;
            end
        end else begin
            instr_valid <= 1'b0;
        end
    end

endmodule
